// File: rtl/spi_apb_sequencer.sv
// -----------------------------------------------------------------------------
// spi_apb_sequencer
//
// APB master for the spi_top register block. After reset it writes SPI_CR1,
// SPI_CR2 and SPI_BR from parameters, then serves two requesters round-robin:
// write SPI_DR, poll SPI_SR until SPIF, read SPI_DR, and hand the received
// byte back with a one-cycle done pulse.
//
// Ports
//   PCLK, PRESET       clock (rising edge) and synchronous active-high reset
//   req[1:0]           level request per requester, held until its done
//   tx_data0/1[7:0]    byte to send, sampled when the request is granted
//   done[1:0]          one-cycle pulse to the requester just served
//   rx_data[7:0]       received byte, valid with done, held otherwise
//   err                pulses with done when the transfer failed
//   cfg_done           high once the three configuration writes finished
//   PADDR..PWDATA      APB request outputs
//   PRDATA, PREADY,
//   PSLVERR            APB response inputs, sampled on the completing edge
// -----------------------------------------------------------------------------
module spi_apb_sequencer #(
    parameter logic [7:0]  CR1_INIT = 8'hD0,
    parameter logic [7:0]  CR2_INIT = 8'h12,
    parameter logic [7:0]  BR_INIT  = 8'h25,
    parameter int unsigned POLL_MAX = 64
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [1:0] req,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    output logic [1:0] done,
    output logic [7:0] rx_data,
    output logic       err,
    output logic       cfg_done,
    output logic [2:0] PADDR,
    output logic       PWRITE,
    output logic       PSEL,
    output logic       PENABLE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    localparam logic [2:0] ST_CFG_CR1 = 3'd0;
    localparam logic [2:0] ST_CFG_CR2 = 3'd1;
    localparam logic [2:0] ST_CFG_BR  = 3'd2;
    localparam logic [2:0] ST_IDLE    = 3'd3;
    localparam logic [2:0] ST_WR_DR   = 3'd4;
    localparam logic [2:0] ST_POLL_SR = 3'd5;
    localparam logic [2:0] ST_RD_DR   = 3'd6;
    localparam logic [2:0] ST_FINISH  = 3'd7;

    // Every APB access walks GAP -> SETUP -> ACCESS. GAP keeps PSEL low for
    // one cycle, which is what forbids back-to-back accesses.
    localparam logic [1:0] PH_GAP    = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_ACCESS = 2'd2;

    localparam logic [2:0] ADDR_CR1 = 3'b000;
    localparam logic [2:0] ADDR_CR2 = 3'b001;
    localparam logic [2:0] ADDR_BR  = 3'b010;
    localparam logic [2:0] ADDR_SR  = 3'b011;
    localparam logic [2:0] ADDR_DR  = 3'b101;

    localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

    logic [2:0] state;
    logic [1:0] phase;
    logic       idx;        // requester being served
    logic       prio;       // requester that wins a tie at the next grant
    logic [7:0] tx_byte;
    logic [7:0] poll_cnt;

    logic [2:0] acc_addr;
    logic       acc_write;
    logic [7:0] acc_wdata;
    logic       grant_idx;
    logic [7:0] poll_next;
    logic [1:0] done_onehot;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        acc_addr  = ADDR_CR1;
        acc_write = 1'b1;
        acc_wdata = CR1_INIT;
        case (state)
            ST_CFG_CR2: begin
                acc_addr  = ADDR_CR2;
                acc_wdata = CR2_INIT;
            end
            ST_CFG_BR: begin
                acc_addr  = ADDR_BR;
                acc_wdata = BR_INIT;
            end
            ST_WR_DR: begin
                acc_addr  = ADDR_DR;
                acc_wdata = tx_byte;
            end
            ST_POLL_SR: begin
                acc_addr  = ADDR_SR;
                acc_write = 1'b0;
                acc_wdata = 8'h00;
            end
            ST_RD_DR: begin
                acc_addr  = ADDR_DR;
                acc_write = 1'b0;
                acc_wdata = 8'h00;
            end
            default: ;
        endcase
    end

    // The priority requester wins if it asks; otherwise the other one must
    // be the one asking (only evaluated when req is non-zero).
    assign grant_idx   = req[prio] ? prio : ~prio;
    assign poll_next   = poll_cnt + 8'd1;
    assign done_onehot = idx ? 2'b10 : 2'b01;

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of the others, independent of statement order.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= ST_CFG_CR1;
            phase    <= PH_GAP;
            idx      <= 1'b0;
            prio     <= 1'b0;
            tx_byte  <= 8'h00;
            poll_cnt <= 8'h00;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= 3'b000;
            PWDATA   <= 8'h00;
            done     <= 2'b00;
            err      <= 1'b0;
            rx_data  <= 8'h00;
            cfg_done <= 1'b0;
        end else begin
            // done/err are pulses: set on the edge entering FINISH only.
            done <= 2'b00;
            err  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        idx      <= grant_idx;
                        tx_byte  <= grant_idx ? tx_data1 : tx_data0;
                        poll_cnt <= 8'h00;
                        phase    <= PH_GAP;
                        state    <= ST_WR_DR;
                    end
                end

                ST_FINISH: begin
                    prio  <= ~idx;
                    state <= ST_IDLE;
                end

                default: begin
                    case (phase)
                        PH_GAP: begin
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PADDR   <= acc_addr;
                            PWRITE  <= acc_write;
                            PWDATA  <= acc_wdata;
                            phase   <= PH_SETUP;
                        end

                        PH_SETUP: begin
                            PENABLE <= 1'b1;
                            phase   <= PH_ACCESS;
                        end

                        default: begin
                            if (PREADY) begin
                                PSEL    <= 1'b0;
                                PENABLE <= 1'b0;
                                phase   <= PH_GAP;
                                case (state)
                                    // Configuration ignores PSLVERR.
                                    ST_CFG_CR1: state <= ST_CFG_CR2;
                                    ST_CFG_CR2: state <= ST_CFG_BR;
                                    ST_CFG_BR: begin
                                        cfg_done <= 1'b1;
                                        state    <= ST_IDLE;
                                    end
                                    ST_WR_DR: begin
                                        if (PSLVERR) begin
                                            done    <= done_onehot;
                                            err     <= 1'b1;
                                            rx_data <= 8'h00;
                                            state   <= ST_FINISH;
                                        end else begin
                                            state <= ST_POLL_SR;
                                        end
                                    end
                                    ST_POLL_SR: begin
                                        poll_cnt <= poll_next;
                                        if (PSLVERR || (!PRDATA[7] && poll_next == POLL_LIMIT)) begin
                                            done    <= done_onehot;
                                            err     <= 1'b1;
                                            rx_data <= 8'h00;
                                            state   <= ST_FINISH;
                                        end else if (PRDATA[7]) begin
                                            state <= ST_RD_DR;
                                        end
                                        // else: stay and re-read after the gap.
                                    end
                                    ST_RD_DR: begin
                                        done    <= done_onehot;
                                        err     <= PSLVERR;
                                        rx_data <= PSLVERR ? 8'h00 : PRDATA;
                                        state   <= ST_FINISH;
                                    end
                                    default: state <= ST_IDLE;
                                endcase
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_apb_sequencer
//
// Directed bench for spi_apb_sequencer. A behavioural APB slave answers on the
// falling edge (wait states, SR sequence, DR value, optional PSLVERR on the DR
// write) and logs every completed access and every done pulse; the test tasks
// compare those logs against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_spi_apb_sequencer;

    localparam int POLL_MAX = 4;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] tx_data0 = 8'h00;
    logic [7:0] tx_data1 = 8'h00;
    logic [1:0] done;
    logic [7:0] rx_data;
    logic       err;
    logic       cfg_done;
    logic [2:0] PADDR;
    logic       PWRITE;
    logic       PSEL;
    logic       PENABLE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = 8'h00;
    logic       PREADY = 1'b0;
    logic       PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;

    spi_apb_sequencer #(
        .CR1_INIT (8'hD0),
        .CR2_INIT (8'h12),
        .BR_INIT  (8'h25),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req      (req),
        .tx_data0 (tx_data0),
        .tx_data1 (tx_data1),
        .done     (done),
        .rx_data  (rx_data),
        .err      (err),
        .cfg_done (cfg_done),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- slave
    typedef struct packed {
        logic [2:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic [3:0] len;    // cycles from SETUP to completion, inclusive
    } acc_t;

    acc_t       acc_log[$];
    logic [1:0] done_log[$];
    logic [7:0] rx_log[$];
    logic       err_log[$];

    logic [7:0] sr_q[$];
    logic [7:0] sr_default = 8'h80;
    logic [7:0] dr_value = 8'h00;
    int         wait_states = 0;
    logic       err_on_dr_wr = 1'b0;

    int         stable_viol = 0;
    int         b2b_viol = 0;
    logic [2:0] s_addr = 3'b000;
    logic       s_wr = 1'b0;
    logic [7:0] s_wdata = 8'h00;
    int         wait_cnt = 0;
    int         acc_len = 0;
    logic       prev_complete = 1'b0;

    always @(negedge PCLK) begin
        if (done !== 2'b00) begin
            done_log.push_back(done);
            rx_log.push_back(rx_data);
            err_log.push_back(err);
        end
        if (prev_complete && PSEL) b2b_viol++;
        prev_complete = 1'b0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 8'h00;
        if (PSEL && !PENABLE) begin
            s_addr   = PADDR;
            s_wr     = PWRITE;
            s_wdata  = PWDATA;
            wait_cnt = 0;
            acc_len  = 1;
        end else if (PSEL && PENABLE) begin
            acc_len++;
            if (PADDR !== s_addr || PWRITE !== s_wr || PWDATA !== s_wdata) stable_viol++;
            if (wait_cnt < wait_states) begin
                wait_cnt++;
            end else begin
                PREADY = 1'b1;
                if (!PWRITE && PADDR == 3'b011) begin
                    if (sr_q.size() > 0) PRDATA = sr_q.pop_front();
                    else PRDATA = sr_default;
                end else if (!PWRITE && PADDR == 3'b101) begin
                    PRDATA = dr_value;
                end
                PSLVERR = PWRITE && PADDR == 3'b101 && err_on_dr_wr;
                acc_log.push_back('{addr: PADDR, wr: PWRITE, wdata: PWDATA,
                                    rdata: PRDATA, len: acc_len[3:0]});
                prev_complete = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        done_log.delete();
        rx_log.delete();
        err_log.delete();
        stable_viol = 0;
        b2b_viol = 0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (done_log.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (done_log.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d done pulses, expected %0d", name, done_log.size(), n);
        end
    endtask

    task automatic wait_cfg(input int budget, input string name);
        int k;
        k = 0;
        while (cfg_done !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_cfg_done: got %b, expected 1", name, cfg_done);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [25:0] outs;
        PRESET = 1'b1;
        req = 2'b00;
        tick(3);
        outs = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, done, err, rx_data, cfg_done};
        checks++;
        if (outs !== 26'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
    endtask

    task automatic test_config(input string name);
        logic [2:0] ea [3];
        logic [7:0] ed [3];
        ea = '{3'b000, 3'b001, 3'b010};
        ed = '{8'hD0, 8'h12, 8'h25};
        wait_cfg(60, name);
        checks++;
        if (acc_log.size() != 3) begin
            errors++;
            $display("FAIL %s_count: got %0d accesses at cfg_done, expected 3", name, acc_log.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= acc_log.size() ||
                {acc_log[i].addr, acc_log[i].wr, acc_log[i].wdata, acc_log[i].len} !== {ea[i], 1'b1, ed[i], 4'd2}) begin
                errors++;
                $display("FAIL %s_write%0d: got addr=%b wr=%b data=%h len=%0d, expected addr=%b wr=1 data=%h len=2",
                         name, i, acc_log[i].addr, acc_log[i].wr, acc_log[i].wdata, acc_log[i].len, ea[i], ed[i]);
            end
        end
        checks++;
        if (b2b_viol != 0) begin
            errors++;
            $display("FAIL %s_gap: got %0d back-to-back accesses, expected 0", name, b2b_viol);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] wq[$];
        logic [1:0] exp_done;
        logic [7:0] exp_w;
        clear_logs();
        sr_q.delete();
        sr_default = 8'h80;
        dr_value = 8'h33;
        tx_data0 = 8'h11;
        tx_data1 = 8'h22;
        req = 2'b11;
        wait_done(4, 200, "rr");
        req = 2'b00;
        tick(10);
        checks++;
        if (done_log.size() != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d done pulses, expected 4", done_log.size());
        end
        foreach (acc_log[i]) if (acc_log[i].wr && acc_log[i].addr == 3'b101) wq.push_back(acc_log[i].wdata);
        for (int i = 0; i < 4; i++) begin
            exp_done = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_w    = (i % 2 == 0) ? 8'h11 : 8'h22;
            checks++;
            if (i >= done_log.size() || {done_log[i], err_log[i], rx_log[i]} !== {exp_done, 1'b0, 8'h33}) begin
                errors++;
                $display("FAIL rr_done%0d: got done=%b err=%b rx=%h, expected done=%b err=0 rx=33",
                         i, done_log[i], err_log[i], rx_log[i], exp_done);
            end
            checks++;
            if (i >= wq.size() || wq[i] !== exp_w) begin
                errors++;
                $display("FAIL rr_wdata%0d: got %h, expected %h", i, wq[i], exp_w);
            end
        end
    endtask

    task automatic test_wait_states();
        logic [2:0] ea [4];
        ea = '{3'b101, 3'b011, 3'b011, 3'b101};
        clear_logs();
        wait_states = 3;
        sr_q = '{8'h00, 8'h80};
        dr_value = 8'hC3;
        tx_data1 = 8'h96;
        req = 2'b10;
        wait_done(1, 300, "ws");
        req = 2'b00;
        tick(5);
        wait_states = 0;
        checks++;
        if (acc_log.size() != 4) begin
            errors++;
            $display("FAIL ws_count: got %0d accesses, expected 4", acc_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= acc_log.size() || {acc_log[i].addr, acc_log[i].len} !== {ea[i], 4'd5}) begin
                errors++;
                $display("FAIL ws_access%0d: got addr=%b len=%0d, expected addr=%b len=5",
                         i, acc_log[i].addr, acc_log[i].len, ea[i]);
            end
        end
        checks++;
        if (acc_log.size() < 1 || acc_log[0].wdata !== 8'h96) begin
            errors++;
            $display("FAIL ws_wdata: got %h, expected 96", acc_log[0].wdata);
        end
        checks++;
        if (stable_viol != 0) begin
            errors++;
            $display("FAIL ws_stable: got %0d unstable stall cycles, expected 0", stable_viol);
        end
        checks++;
        if (done_log.size() != 1 || {done_log[0], err_log[0], rx_log[0]} !== {2'b10, 1'b0, 8'hC3}) begin
            errors++;
            $display("FAIL ws_result: got done=%b err=%b rx=%h, expected done=10 err=0 rx=c3",
                     done_log[0], err_log[0], rx_log[0]);
        end
    endtask

    task automatic test_poll_timeout();
        int sr_reads;
        clear_logs();
        sr_q.delete();
        sr_default = 8'h00;
        tx_data1 = 8'h3C;
        req = 2'b10;
        wait_done(1, 200, "to");
        req = 2'b00;
        tick(5);
        sr_default = 8'h80;
        sr_reads = 0;
        foreach (acc_log[i]) if (!acc_log[i].wr && acc_log[i].addr == 3'b011) sr_reads++;
        checks++;
        if (sr_reads != POLL_MAX) begin
            errors++;
            $display("FAIL to_sr_reads: got %0d, expected %0d", sr_reads, POLL_MAX);
        end
        checks++;
        if (acc_log.size() != 5) begin
            errors++;
            $display("FAIL to_count: got %0d accesses, expected 5 (no DR read)", acc_log.size());
        end
        checks++;
        if (done_log.size() != 1 || {done_log[0], err_log[0], rx_log[0]} !== {2'b10, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL to_result: got done=%b err=%b rx=%h, expected done=10 err=1 rx=00",
                     done_log[0], err_log[0], rx_log[0]);
        end
    endtask

    task automatic test_single();
        acc_t exp [5];
        exp[0] = '{addr: 3'b101, wr: 1'b1, wdata: 8'hAA, rdata: 8'h00, len: 4'd2};
        exp[1] = '{addr: 3'b011, wr: 1'b0, wdata: 8'h00, rdata: 8'h00, len: 4'd2};
        exp[2] = '{addr: 3'b011, wr: 1'b0, wdata: 8'h00, rdata: 8'h00, len: 4'd2};
        exp[3] = '{addr: 3'b011, wr: 1'b0, wdata: 8'h00, rdata: 8'h80, len: 4'd2};
        exp[4] = '{addr: 3'b101, wr: 1'b0, wdata: 8'h00, rdata: 8'h5C, len: 4'd2};
        clear_logs();
        sr_q = '{8'h00, 8'h00, 8'h80};
        dr_value = 8'h5C;
        tx_data0 = 8'hAA;
        req = 2'b01;
        wait_done(1, 200, "single");
        req = 2'b00;
        tick(6);
        checks++;
        if (acc_log.size() != 5) begin
            errors++;
            $display("FAIL single_count: got %0d accesses, expected 5", acc_log.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= acc_log.size() || acc_log[i] !== exp[i]) begin
                errors++;
                $display("FAIL single_access%0d: got %h, expected %h", i, acc_log[i], exp[i]);
            end
        end
        checks++;
        if (done_log.size() != 1 || {done_log[0], err_log[0], rx_log[0]} !== {2'b01, 1'b0, 8'h5C}) begin
            errors++;
            $display("FAIL single_result: got %0d pulses done=%b err=%b rx=%h, expected 1 pulse done=01 err=0 rx=5c",
                     done_log.size(), done_log[0], err_log[0], rx_log[0]);
        end
        checks++;
        if ({done, err, rx_data} !== {2'b00, 1'b0, 8'h5C}) begin
            errors++;
            $display("FAIL single_hold: got done=%b err=%b rx=%h, expected done=00 err=0 rx=5c", done, err, rx_data);
        end
    endtask

    task automatic test_dr_error();
        clear_logs();
        err_on_dr_wr = 1'b1;
        dr_value = 8'h77;
        tx_data0 = 8'h5A;
        req = 2'b01;
        wait_done(1, 200, "drerr");
        req = 2'b00;
        tick(5);
        err_on_dr_wr = 1'b0;
        checks++;
        if (acc_log.size() != 1) begin
            errors++;
            $display("FAIL drerr_count: got %0d accesses, expected 1 (no SR poll)", acc_log.size());
        end
        checks++;
        if (done_log.size() != 1 || {done_log[0], err_log[0], rx_log[0]} !== {2'b01, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL drerr_result: got done=%b err=%b rx=%h, expected done=01 err=1 rx=00",
                     done_log[0], err_log[0], rx_log[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] outs;
        int k;
        clear_logs();
        sr_q.delete();
        sr_default = 8'h00;
        tx_data0 = 8'hE7;
        req = 2'b01;
        k = 0;
        while (acc_log.size() < 3 && k < 100) begin
            tick(1);
            k++;
        end
        checks++;
        if (acc_log.size() < 3) begin
            errors++;
            $display("FAIL rstmid_poll: got %0d accesses, expected at least 3", acc_log.size());
        end
        PRESET = 1'b1;
        tick(1);
        outs = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, done, err, rx_data, cfg_done};
        checks++;
        if (outs !== 26'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h, expected 0", outs);
        end
        clear_logs();
        req = 2'b00;
        sr_default = 8'h80;
        tick(1);
        PRESET = 1'b0;
        test_config("recfg");
        tick(5);
        checks++;
        if (done_log.size() != 0) begin
            errors++;
            $display("FAIL rstmid_done: got %0d done pulses, expected 0", done_log.size());
        end
    endtask

    initial begin
        test_reset();
        PRESET = 1'b0;
        test_config("cfg");
        test_round_robin();
        test_wait_states();
        test_poll_timeout();
        test_single();
        test_dr_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
